// File: rtl/coin_event_scheduler.sv
// Captures drift-tube hit patterns over a fixed window after each scintillator
// coincidence and writes one header word plus four group words to the event FIFO.
module coin_event_scheduler #(
  parameter int WINDOW = 32,
  parameter int EVT_W  = 12
) (
  input  logic             clk100,
  input  logic             rst_n,
  input  logic             SCIN_COIN,
  input  logic [7:0]       TUBE3A,
  input  logic [7:0]       TUBE3B,
  input  logic [7:0]       TUBE4A,
  input  logic [7:0]       TUBE4B,
  input  logic             WR_FULL,
  input  logic             CLR_OVERFLOW,
  output logic             WR_EN,
  output logic [15:0]      WR_DATA,
  output logic             BUSY,
  output logic             OVERFLOW,
  output logic [EVT_W-1:0] EVENT_COUNT,
  output logic [7:0]       DROP_COUNT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              coin_meta_q, coin_meta_d;
  logic              coin_sync_q, coin_sync_d;
  logic              coin_prev_q, coin_prev_d;
  logic [3:0][7:0]   tube_meta_q, tube_meta_d;
  logic [3:0][7:0]   tube_sync_q, tube_sync_d;
  logic [3:0][7:0]   acc_q, acc_d;
  logic [7:0]        win_cnt_q, win_cnt_d;
  logic [EVT_W-1:0]  ev_num_q, ev_num_d;
  logic [EVT_W-1:0]  evt_cnt_q, evt_cnt_d;
  logic [2:0]        w_q, w_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        drop_q, drop_d;

  logic              trig;
  logic              ovf_set;
  logic [1:0]        drop_inc;
  logic [8:0]        drop_sum;
  logic [1:0]        w_idx;
  logic [11:0]       ev12;

  // FIFO write side: a word is transferred on every clock where WR_EN is high;
  // WR_EN is only raised while WR_FULL is low, so WR_FULL acts as the ready.
  always_comb begin
    coin_meta_d = SCIN_COIN;
    coin_sync_d = coin_meta_q;
    coin_prev_d = coin_sync_q;
    tube_meta_d = {TUBE4B, TUBE4A, TUBE3B, TUBE3A};
    tube_sync_d = tube_meta_q;
    state_d     = state_q;
    acc_d       = acc_q;
    win_cnt_d   = win_cnt_q;
    ev_num_d    = ev_num_q;
    evt_cnt_d   = evt_cnt_q;
    w_d         = w_q;
    ovf_set     = 1'b0;
    drop_inc    = 2'd0;
    trig        = coin_sync_q & ~coin_prev_q;
    WR_EN       = (state_q == S_WRITE) && !WR_FULL;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d   = S_COLLECT;
          acc_d     = tube_sync_q;
          win_cnt_d = 8'(WINDOW - 1);
          ev_num_d  = evt_cnt_q;
          evt_cnt_d = evt_cnt_q + 1'b1;
        end
      end
      S_COLLECT: begin
        acc_d = acc_q | tube_sync_q;
        if (trig) drop_inc = drop_inc + 2'd1;
        if (win_cnt_q == 8'd0) begin
          if (WR_FULL) begin
            drop_inc = drop_inc + 2'd1;
            ovf_set  = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WRITE;
            w_d     = 3'd0;
          end
        end else begin
          win_cnt_d = win_cnt_q - 8'd1;
        end
      end
      S_WRITE: begin
        if (trig) drop_inc = drop_inc + 2'd1;
        if (WR_EN) begin
          if (w_q == 3'd4) begin
            state_d = S_IDLE;
            w_d     = 3'd0;
          end else begin
            w_d = w_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    ovf_d    = ovf_set | (ovf_q & ~CLR_OVERFLOW);

    // Word index 1..4 selects groups 3A, 3B, 4A, 4B.
    w_idx   = 2'(w_q - 3'd1);
    ev12    = 12'(ev_num_q);
    WR_DATA = 16'h0000;
    if (WR_EN) begin
      if (w_q == 3'd0) WR_DATA = {2'b10, 2'b00, ev12};
      else             WR_DATA = {2'b01, w_idx, ev12[3:0], acc_q[w_idx]};
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      coin_meta_q <= 1'b0;
      coin_sync_q <= 1'b0;
      coin_prev_q <= 1'b0;
      tube_meta_q <= '0;
      tube_sync_q <= '0;
      acc_q       <= '0;
      win_cnt_q   <= 8'd0;
      ev_num_q    <= '0;
      evt_cnt_q   <= '0;
      w_q         <= 3'd0;
      ovf_q       <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      coin_meta_q <= coin_meta_d;
      coin_sync_q <= coin_sync_d;
      coin_prev_q <= coin_prev_d;
      tube_meta_q <= tube_meta_d;
      tube_sync_q <= tube_sync_d;
      acc_q       <= acc_d;
      win_cnt_q   <= win_cnt_d;
      ev_num_q    <= ev_num_d;
      evt_cnt_q   <= evt_cnt_d;
      w_q         <= w_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  assign BUSY        = (state_q != S_IDLE);
  assign OVERFLOW    = ovf_q;
  assign EVENT_COUNT = evt_cnt_q;
  assign DROP_COUNT  = drop_q;

endmodule

// File: tb/tb_coin_event_scheduler.sv
// Directed bench for coin_event_scheduler: one task per scenario, each with
// hand-computed expected FIFO words and counter values.
module tb_coin_event_scheduler;

  logic        clk100 = 1'b0;
  logic        rst_n;
  logic        SCIN_COIN;
  logic [7:0]  TUBE3A, TUBE3B, TUBE4A, TUBE4B;
  logic        WR_FULL;
  logic        CLR_OVERFLOW;
  logic        WR_EN;
  logic [15:0] WR_DATA;
  logic        BUSY;
  logic        OVERFLOW;
  logic [11:0] EVENT_COUNT;
  logic [7:0]  DROP_COUNT;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          got_cyc[$];
  int          nz_idle;

  always #5 clk100 = ~clk100;

  coin_event_scheduler #(.WINDOW(32), .EVT_W(12)) dut (
    .clk100       (clk100),
    .rst_n        (rst_n),
    .SCIN_COIN    (SCIN_COIN),
    .TUBE3A       (TUBE3A),
    .TUBE3B       (TUBE3B),
    .TUBE4A       (TUBE4A),
    .TUBE4B       (TUBE4B),
    .WR_FULL      (WR_FULL),
    .CLR_OVERFLOW (CLR_OVERFLOW),
    .WR_EN        (WR_EN),
    .WR_DATA      (WR_DATA),
    .BUSY         (BUSY),
    .OVERFLOW     (OVERFLOW),
    .EVENT_COUNT  (EVENT_COUNT),
    .DROP_COUNT   (DROP_COUNT)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n        = 1'b0;
    SCIN_COIN    = 1'b0;
    TUBE3A       = 8'h00;
    TUBE3B       = 8'h00;
    TUBE4A       = 8'h00;
    TUBE4B       = 8'h00;
    WR_FULL      = 1'b0;
    CLR_OVERFLOW = 1'b0;
    repeat (2) @(negedge clk100);
    rst_n = 1'b1;
    repeat (2) @(negedge clk100);
  endtask

  // Records written words and the negedge index (from call) they appeared on.
  task automatic collect(input int budget, input int n);
    got_q.delete();
    got_cyc.delete();
    nz_idle = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk100);
      if (WR_EN === 1'b1) begin
        got_q.push_back(WR_DATA);
        got_cyc.push_back(c);
      end else if (WR_DATA !== 16'h0000) begin
        nz_idle++;
      end
      if (got_q.size() >= n) break;
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    SCIN_COIN    = 1'b0;
    TUBE3A       = 8'h00;
    TUBE3B       = 8'h00;
    TUBE4A       = 8'h00;
    TUBE4B       = 8'h00;
    WR_FULL      = 1'b0;
    CLR_OVERFLOW = 1'b0;
    repeat (3) @(negedge clk100);
    checks++; if (WR_EN !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", WR_EN); end
    checks++; if (WR_DATA !== 16'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0000", WR_DATA); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", OVERFLOW); end
    checks++; if (EVENT_COUNT !== 12'd0) begin failures++; $display("FAIL reset_event_count got=%0d exp=0", EVENT_COUNT); end
    checks++; if (DROP_COUNT !== 8'd0) begin failures++; $display("FAIL reset_drop_count got=%0d exp=0", DROP_COUNT); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk100);
    checks++; if (BUSY !== 1'b0 || WR_EN !== 1'b0) begin failures++; $display("FAIL reset_release_idle busy=%b wr_en=%b exp=0/0", BUSY, WR_EN); end
  endtask

  task automatic test_single_event();
    logic [15:0] g;
    do_reset();
    exp_q = '{16'h8000, 16'h4010, 16'h5008, 16'h6002, 16'h7001};
    fork
      begin
        SCIN_COIN = 1'b1; #100; SCIN_COIN = 1'b0;
        #30 TUBE3A = 8'h10;
        #30 TUBE3B = 8'h08;
        #40 TUBE4A = 8'h02;
        #20 TUBE4B = 8'h01;
        #20 begin TUBE3A = 8'h00; TUBE3B = 8'h00; TUBE4A = 8'h00; TUBE4B = 8'h00; end
      end
      collect(60, 5);
    join
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL single_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL single_word%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
    if (got_q.size() == 5) begin
      checks++; if (got_cyc[0] != 35) begin failures++; $display("FAIL single_latency got=%0d exp=35", got_cyc[0]); end
      checks++; if (got_cyc[4] - got_cyc[0] != 4) begin failures++; $display("FAIL single_consecutive span=%0d exp=4", got_cyc[4] - got_cyc[0]); end
    end
    checks++; if (nz_idle != 0) begin failures++; $display("FAIL single_idle_data nonzero_cycles=%0d exp=0", nz_idle); end
    checks++; if (EVENT_COUNT !== 12'd1) begin failures++; $display("FAIL single_event_count got=%0d exp=1", EVENT_COUNT); end
    @(negedge clk100);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", BUSY); end
  endtask

  task automatic test_pre_trigger_hit();
    logic [15:0] g;
    do_reset();
    exp_q = '{16'h8000, 16'h4000, 16'h5000, 16'h6000, 16'h7000};
    fork
      begin
        TUBE3A = 8'h10; #30; TUBE3A = 8'h00;
        #30 SCIN_COIN = 1'b1;
        #100 SCIN_COIN = 1'b0;
      end
      begin
        #60;
        collect(60, 5);
      end
    join
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL pretrig_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL pretrig_word%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_fifo_full_drop();
    do_reset();
    WR_FULL = 1'b1;
    fork
      begin SCIN_COIN = 1'b1; #100; SCIN_COIN = 1'b0; end
      collect(45, 1);
    join
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL full_no_write got=%0d words exp=0", got_q.size()); end
    checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL full_overflow got=%b exp=1", OVERFLOW); end
    checks++; if (DROP_COUNT !== 8'd1) begin failures++; $display("FAIL full_drop_count got=%0d exp=1", DROP_COUNT); end
    checks++; if (EVENT_COUNT !== 12'd1) begin failures++; $display("FAIL full_event_count got=%0d exp=1", EVENT_COUNT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL full_busy got=%b exp=0", BUSY); end
    WR_FULL = 1'b0;
    repeat (3) @(negedge clk100);
    checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL full_overflow_sticky got=%b exp=1", OVERFLOW); end
    CLR_OVERFLOW = 1'b1;
    @(negedge clk100);
    CLR_OVERFLOW = 1'b0;
    checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL full_overflow_clear got=%b exp=0", OVERFLOW); end
  endtask

  task automatic test_mid_event_stall();
    logic [15:0] g;
    logic [15:0] hdr;
    int          stall_bad;
    do_reset();
    exp_q = '{16'h8000, 16'h4081, 16'h5042, 16'h6024, 16'h7018};
    TUBE3A = 8'h81; TUBE3B = 8'h42; TUBE4A = 8'h24; TUBE4B = 8'h18;
    hdr = 16'hxxxx;
    stall_bad = 0;
    fork
      begin SCIN_COIN = 1'b1; #100; SCIN_COIN = 1'b0; end
      begin
        collect(60, 1);
        if (got_q.size() > 0) hdr = got_q[0];
        @(posedge clk100);
        #1 WR_FULL = 1'b1;
        repeat (4) begin
          @(negedge clk100);
          if (WR_EN !== 1'b0 || BUSY !== 1'b1) stall_bad++;
        end
        @(posedge clk100);
        #1 WR_FULL = 1'b0;
        collect(20, 4);
      end
    join
    checks++; if (hdr !== exp_q[0]) begin failures++; $display("FAIL stall_header got=%h exp=%h", hdr, exp_q[0]); end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_wr_en bad_cycles=%0d exp=0", stall_bad); end
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL stall_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      checks++; if (g !== exp_q[i+1]) begin failures++; $display("FAIL stall_word%0d got=%h exp=%h", i + 1, g, exp_q[i+1]); end
    end
    if (got_q.size() == 4) begin
      checks++; if (got_cyc[3] - got_cyc[0] != 3) begin failures++; $display("FAIL stall_resume_span got=%0d exp=3", got_cyc[3] - got_cyc[0]); end
    end
    TUBE3A = 8'h00; TUBE3B = 8'h00; TUBE4A = 8'h00; TUBE4B = 8'h00;
    collect(10, 1);
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL stall_extra_words got=%0d exp=0", got_q.size()); end
    checks++; if (DROP_COUNT !== 8'd0 || OVERFLOW !== 1'b0) begin failures++; $display("FAIL stall_no_drop drop=%0d ovf=%b exp=0/0", DROP_COUNT, OVERFLOW); end
  endtask

  task automatic test_retrigger_busy();
    logic [15:0] g;
    do_reset();
    exp_q = '{16'h8000, 16'h4000, 16'h5000, 16'h6000, 16'h7000};
    fork
      begin
        SCIN_COIN = 1'b1; #100; SCIN_COIN = 1'b0;
        #30 SCIN_COIN = 1'b1;
        #50 SCIN_COIN = 1'b0;
      end
      collect(80, 6);
    join
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL retrig_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL retrig_word%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
    checks++; if (DROP_COUNT !== 8'd1) begin failures++; $display("FAIL retrig_drop_count got=%0d exp=1", DROP_COUNT); end
    checks++; if (EVENT_COUNT !== 12'd1) begin failures++; $display("FAIL retrig_event_count got=%0d exp=1", EVENT_COUNT); end
    checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL retrig_overflow got=%b exp=0", OVERFLOW); end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] g;
    do_reset();
    fork
      begin SCIN_COIN = 1'b1; #100; SCIN_COIN = 1'b0; end
      begin
        collect(60, 2);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (WR_EN !== 1'b0) begin failures++; $display("FAIL midrst_wr_en got=%b exp=0", WR_EN); end
        checks++; if (WR_DATA !== 16'h0) begin failures++; $display("FAIL midrst_wr_data got=%h exp=0000", WR_DATA); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", BUSY); end
        checks++; if (EVENT_COUNT !== 12'd0) begin failures++; $display("FAIL midrst_event_count got=%0d exp=0", EVENT_COUNT); end
        checks++; if (DROP_COUNT !== 8'd0 || OVERFLOW !== 1'b0) begin failures++; $display("FAIL midrst_drop_ovf drop=%0d ovf=%b exp=0/0", DROP_COUNT, OVERFLOW); end
        #14 rst_n = 1'b1;
      end
    join
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL midrst_pre_words got=%0d exp=2", got_q.size()); end
    collect(40, 1);
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL midrst_abandoned got=%0d words exp=0", got_q.size()); end
    fork
      begin SCIN_COIN = 1'b1; #100; SCIN_COIN = 1'b0; end
      collect(60, 1);
    join
    g = (got_q.size() > 0) ? got_q[0] : 16'hxxxx;
    checks++; if (g !== 16'h8000) begin failures++; $display("FAIL midrst_new_header got=%h exp=8000", g); end
    checks++; if (EVENT_COUNT !== 12'd1) begin failures++; $display("FAIL midrst_new_event_count got=%0d exp=1", EVENT_COUNT); end
    collect(10, 5);
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_pre_trigger_hit();
    test_fifo_full_drop();
    test_mid_event_stall();
    test_retrigger_busy();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coin_event_scheduler.md
Name: coin_event_scheduler

Overview:
Sequences capture of drift-tube hit patterns into the event FIFO on each scintillator coincidence. It opens a fixed collection window on a SCIN_COIN rising edge and OR-accumulates hits from the four 8-bit tube groups (3A, 3B, 4A, 4B). It then writes one header word and four data words through the FIFO write port. It sits between the raw detector inputs and the FIFO write side, and it drives the event counter and overflow indication.

Parameters:
WINDOW, 32, collection window length in clk100 cycles (1..255)
EVT_W, 12, width of the event number counter

Ports:
clk100  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous, active-low reset
SCIN_COIN  in  1  scintillator coincidence, asynchronous level
TUBE3A  in  8  tube group 3A hit bits, asynchronous
TUBE3B  in  8  tube group 3B hit bits, asynchronous
TUBE4A  in  8  tube group 4A hit bits, asynchronous
TUBE4B  in  8  tube group 4B hit bits, asynchronous
WR_FULL  in  1  FIFO full flag, synchronous to clk100
CLR_OVERFLOW  in  1  synchronous clear of OVERFLOW
WR_EN  out  1  FIFO write strobe
WR_DATA  out  16  FIFO write word
BUSY  out  1  high when the state is not IDLE
OVERFLOW  out  1  sticky flag: an event was dropped because the FIFO was full
EVENT_COUNT  out  EVT_W  number of triggers accepted
DROP_COUNT  out  8  saturating count of all dropped or ignored triggers

Behaviour:
- Reset (rst_n low, async): state=IDLE, WR_EN=0, WR_DATA=0, BUSY=0, OVERFLOW=0, EVENT_COUNT=0, DROP_COUNT=0, all sync flops, accumulators and counters=0.
- Input sync: SCIN_COIN and all 32 tube bits pass through 2-flop synchronizers. Trigger = synced SCIN_COIN high AND previous synced value low (rising edge only). A level held high does not retrigger.
- States: IDLE, COLLECT, WRITE.
- IDLE:
  - On trigger: go to COLLECT; load accumulators with the current synced tube values; win_cnt=WINDOW-1; ev_num=EVENT_COUNT; EVENT_COUNT increments (wraps at 2^EVT_W).
- COLLECT:
  - Each cycle, acc_x |= synced TUBEx.
  - When win_cnt==0: if WR_FULL=1, drop the event, set OVERFLOW, increment DROP_COUNT, go to IDLE. Otherwise go to WRITE with word index w=0.
  - Otherwise decrement win_cnt.
- WRITE:
  - WR_EN = (state==WRITE) && !WR_FULL. WR_EN and WR_DATA are combinational from state, w and WR_FULL.
  - w advances only on cycles where WR_EN=1. WR_FULL high mid-event stalls the sequence, with no drop and no data loss.
  - After the write with w=4: go to IDLE.
- Word formats:
  - w=0 header: {2'b10, 2'b00, ev_num[11:0]}.
  - w=1..4 data: {2'b01, idx[1:0], ev_num[3:0], acc}, where idx=0 for 3A, 1 for 3B, 2 for 4A, 3 for 4B, in that order.
  - Empty groups (acc=0) are still written, so every event is exactly 5 words.
- WR_DATA=0 whenever WR_EN=0.
- Triggers seen while in COLLECT or WRITE are ignored and increment DROP_COUNT. They do not set OVERFLOW or change EVENT_COUNT.
- DROP_COUNT saturates at 255.
- OVERFLOW: set has priority over CLR_OVERFLOW in the same cycle.
- Latency: first WR_EN (header, FIFO not full) occurs WINDOW+1 cycles after the cycle the trigger is detected; 2 sync cycles precede detection.
- Back-to-back: a trigger detected in the same cycle the last data word is written is ignored (state is not yet IDLE).
- Reset asserted mid-event: the partial event is abandoned and no further words are written. FIFO contents are the FIFO's responsibility.

Test Plan:
1. Single event, WINDOW=32: pulse SCIN_COIN 100 ns. TUBE3A=8'h10 30 ns after the pulse ends; TUBE3B=8'h08 30 ns later; TUBE4A=8'h02 40 ns later; TUBE4B=8'h01 20 ns later; all cleared after 20 ns. Required: 5 consecutive WR_EN cycles with words 16'h8000, 16'h4010, 16'h5008, 16'h6002, 16'h7001; EVENT_COUNT=1.
2. Pre-trigger hit: TUBE3A=8'h10 for 30 ns, cleared 30 ns before SCIN_COIN rises, no other hits. Required: data words 16'h4000, 16'h5000, 16'h6000, 16'h7000.
3. FIFO full at window end: hold WR_FULL=1 through the last COLLECT cycle. Required: no WR_EN; OVERFLOW=1; DROP_COUNT=1; EVENT_COUNT=1. Then pulse CLR_OVERFLOW; required: OVERFLOW=0.
4. Mid-event stall: raise WR_FULL for 4 cycles after the header is written. Required: WR_EN=0 during the stall; the remaining 4 data words follow in order with none skipped or duplicated.
5. Retrigger while busy: a second SCIN_COIN rising edge 100 ns into COLLECT. Required: exactly 5 words written; DROP_COUNT=1; EVENT_COUNT=1.
6. Async reset during WRITE after 2 words: rst_n low for 15 ns. Required: WR_EN=0 and all outputs 0 immediately. A following event produces header 16'h8000 (event number restarted at 0).
